// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared defaults, constants and state encoding for the MIPS fetch unit
package mips_pkg;

  localparam int          MIPS_ADDR_W   = 32;
  localparam int          MIPS_INSTR_W  = 32;
  localparam logic [31:0] MIPS_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP           = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    REDIR = 2'd2
  } state_e;

endpackage

// File: rtl/mips_ifetch_fifo.sv
// rtl/mips_ifetch_fifo.sv - small synchronous prefetch FIFO with flush and registered head
module mips_ifetch_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 64,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          push_i,
  input  logic [W-1:0]  push_data_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic [W-1:0]  head_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  localparam int PW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          do_push;
  logic          do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  // Storage and pointers; flush drops every entry and wins over push/pop.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= push_data_i;
        wr_ptr_q        <= wr_ptr_q + PW'(1);
      end
      if (do_pop) rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/mips_ifetch.sv
// rtl/mips_ifetch.sv - MIPS instruction fetch: PC, request FSM, redirect and prefetch buffer
module mips_ifetch
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = MIPS_ADDR_W,
  parameter int                INSTR_W  = MIPS_INSTR_W,
  parameter logic [ADDR_W-1:0] RESET_PC = MIPS_RESET_PC,
  parameter int                DEPTH    = 2
) (
  input  logic               sys_clk,
  input  logic               sys_rst_n,
  input  logic               fetch_en,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               imem_rvalid,
  output logic               ir_valid,
  input  logic               ir_ready,
  output logic [INSTR_W-1:0] ir_out,
  output logic [ADDR_W-1:0]  ir_pc,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc
);

  localparam int CW = $clog2(DEPTH) + 1;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   pc_q, pc_d;
  logic [ADDR_W-1:0]   req_pc_q;
  logic                inflight_q, inflight_d;
  logic                kill_q, kill_d;

  logic [CW-1:0]       fifo_count;
  logic                fifo_full;
  logic                fifo_empty;
  logic [INSTR_W+ADDR_W-1:0] fifo_head;
  logic                push;
  logic                pop;
  logic                space_ok;
  logic                unused_redirect_lsbs;

  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  // Outstanding requests reserve a slot so a returning word always fits.
  assign space_ok  = !fifo_full && ((fifo_count + CW'(inflight_q)) < CW'(DEPTH));
  assign imem_addr = pc_q;
  assign push      = imem_rvalid && inflight_q && !kill_q;
  assign pop       = ir_valid && ir_ready;
  assign ir_valid  = !fifo_empty;
  assign {ir_out, ir_pc} = fifo_head;

  // Next-state, request strobe, PC advance and in-flight/kill tracking.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inflight_d = inflight_q;
    kill_d     = kill_q;
    imem_req   = 1'b0;

    case (state_q)
      IDLE:    if (fetch_en) state_d = RUN;
      RUN:     if (!fetch_en) state_d = IDLE;
      REDIR:   state_d = fetch_en ? RUN : IDLE;
      default: state_d = IDLE;
    endcase

    if ((state_q == RUN || state_q == REDIR) && fetch_en && !redirect_valid && space_ok)
      imem_req = 1'b1;

    if (imem_req)         inflight_d = 1'b1;
    else if (imem_rvalid) inflight_d = 1'b0;

    if (redirect_valid) begin
      state_d = REDIR;
      pc_d    = {redirect_pc[ADDR_W-1:2], 2'b00};
      // A response landing this cycle is already flushed; only a later one needs killing.
      kill_d  = inflight_q && !imem_rvalid;
    end else begin
      if (imem_req)    pc_d   = pc_q + ADDR_W'(4);
      if (imem_rvalid) kill_d = 1'b0;
    end
  end

  // Control registers; the request PC travels alongside the outstanding read.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      state_q    <= IDLE;
      pc_q       <= RESET_PC;
      req_pc_q   <= '0;
      inflight_q <= 1'b0;
      kill_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      kill_q     <= kill_d;
      if (imem_req) req_pc_q <= pc_q;
    end
  end

  mips_ifetch_fifo #(
    .DEPTH (DEPTH),
    .W     (INSTR_W + ADDR_W),
    .CW    (CW)
  ) u_fifo (
    .clk_i       (sys_clk),
    .rst_ni      (sys_rst_n),
    .push_i      (push),
    .push_data_i ({imem_rdata, req_pc_q}),
    .pop_i       (pop),
    .flush_i     (redirect_valid),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .full_o      (fifo_full),
    .empty_o     (fifo_empty)
  );

endmodule

// File: tb/tb_mips_ifetch.sv
// tb/tb_mips_ifetch.sv - directed self-checking bench for mips_ifetch
module tb_mips_ifetch;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        fetch_en = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata = 32'h0;
  logic        imem_rvalid = 1'b0;
  logic        ir_valid;
  logic        ir_ready = 1'b0;
  logic [31:0] ir_out;
  logic [31:0] ir_pc;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = 32'h0;

  int n_checks = 0;
  int n_err    = 0;

  logic [31:0] req_log[$];
  logic [31:0] xpc[$];
  logic [31:0] xins[$];

  mips_ifetch dut (
    .sys_clk        (sys_clk),
    .sys_rst_n      (sys_rst_n),
    .fetch_en       (fetch_en),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_rdata     (imem_rdata),
    .imem_rvalid    (imem_rvalid),
    .ir_valid       (ir_valid),
    .ir_ready       (ir_ready),
    .ir_out         (ir_out),
    .ir_pc          (ir_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic logic [31:0] word_at(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h200000C2;
      32'h4:   return 32'h20000555;
      32'h8:   return 32'h00200820;
      default: return a ^ 32'hA5A5_0000;
    endcase
  endfunction

  // Synchronous memory: one-cycle read latency, keeps answering through reset.
  always @(posedge sys_clk) begin
    imem_rvalid <= imem_req;
    imem_rdata  <= word_at(imem_addr);
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    #1;
    if (imem_req) req_log.push_back(imem_addr);
    if (ir_valid && ir_ready) begin
      xpc.push_back(ir_pc);
      xins.push_back(ir_out);
    end
    @(negedge sys_clk);
  endtask

  task automatic clear_logs();
    req_log.delete();
    xpc.delete();
    xins.delete();
  endtask

  task automatic do_reset();
    sys_rst_n = 1'b0;
    fetch_en = 1'b0;
    ir_ready = 1'b0;
    redirect_valid = 1'b0;
    cyc();
    cyc();
    sys_rst_n = 1'b1;
    clear_logs();
  endtask

  task automatic wait_req(input string tag, input int maxc);
    #1;
    for (int i = 0; i < maxc && !imem_req; i++) begin
      cyc();
      #1;
    end
    check(tag, 64'(imem_req), 64'd1);
  endtask

  task automatic wait_xfer(input string tag, input int n, input int maxc);
    for (int i = 0; i < maxc && xpc.size() < n; i++) cyc();
    check(tag, 64'(xpc.size()), 64'(n));
  endtask

  logic [31:0] exp_pc2  [5] = '{32'h0, 32'h4, 32'h8, 32'hC, 32'h10};
  logic [31:0] exp_ins2 [5] = '{32'h200000C2, 32'h20000555, 32'h00200820, 32'hA5A5000C, 32'hA5A50010};
  logic [31:0] exp_pc4  [3] = '{32'hFFFF_FFFC, 32'h0, 32'h4};
  logic [31:0] exp_ins4 [3] = '{32'h5A5A_FFFC, 32'h200000C2, 32'h20000555};

  initial begin
    // Reset values
    sys_rst_n = 1'b0;
    cyc();
    #1;
    check("rst_req",   64'(imem_req),  64'd0);
    check("rst_addr",  64'(imem_addr), 64'h0);
    check("rst_valid", 64'(ir_valid),  64'd0);
    check("rst_ir",    64'(ir_out),    64'h0);
    check("rst_pc",    64'(ir_pc),     64'h0);

    // 1: straight-line fetch
    do_reset();
    fetch_en = 1'b1;
    ir_ready = 1'b1;
    wait_req("t1_first_req", 10);
    check("t1_first_addr", 64'(imem_addr), 64'h0);
    cyc();
    cyc();
    #1;
    check("t1_valid", 64'(ir_valid), 64'd1);
    check("t1_ir0",   64'(ir_out),   64'h200000C2);
    check("t1_pc0",   64'(ir_pc),    64'h0);
    wait_xfer("t1_xfers", 3, 20);
    check("t1_pc1", 64'(xpc[1]),  64'h4);
    check("t1_ir1", 64'(xins[1]), 64'h20000555);
    check("t1_pc2", 64'(xpc[2]),  64'h8);
    check("t1_ir2", 64'(xins[2]), 64'h00200820);

    // 2: backpressure
    do_reset();
    fetch_en = 1'b1;
    ir_ready = 1'b0;
    repeat (8) cyc();
    check("t2_nreq",  64'(req_log.size()), 64'd2);
    check("t2_req0",  64'(req_log[0]),     64'h0);
    check("t2_req1",  64'(req_log[1]),     64'h4);
    #1;
    check("t2_req_full", 64'(imem_req), 64'd0);
    check("t2_valid",    64'(ir_valid), 64'd1);
    check("t2_ir_hold",  64'(ir_out),   64'h200000C2);
    check("t2_pc_hold",  64'(ir_pc),    64'h0);
    ir_ready = 1'b1;
    wait_xfer("t2_xfers", 5, 40);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("t2_pc%0d", i), 64'(xpc[i]),  64'(exp_pc2[i]));
      check($sformatf("t2_ir%0d", i), 64'(xins[i]), 64'(exp_ins2[i]));
    end

    // 3: redirect with one entry buffered and one response landing
    do_reset();
    fetch_en = 1'b1;
    ir_ready = 1'b0;
    repeat (3) cyc();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    #1;
    check("t3_noreq_R", 64'(imem_req), 64'd0);
    cyc();
    redirect_valid = 1'b0;
    ir_ready = 1'b1;
    clear_logs();
    #1;
    check("t3_valid_R1", 64'(ir_valid),  64'd0);
    check("t3_req_R1",   64'(imem_req),  64'd1);
    check("t3_addr_R1",  64'(imem_addr), 64'h100);
    wait_xfer("t3_xfer", 1, 10);
    check("t3_pc0", 64'(xpc[0]),  64'h100);
    check("t3_ir0", 64'(xins[0]), 64'hA5A50100);

    // 4: wrap-around after redirect to the top word
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    cyc();
    redirect_valid = 1'b0;
    clear_logs();
    wait_xfer("t4_xfers", 3, 20);
    for (int i = 0; i < 3; i++) begin
      check($sformatf("t4_req%0d", i), 64'(req_log[i]), 64'(exp_pc4[i]));
      check($sformatf("t4_pc%0d", i),  64'(xpc[i]),     64'(exp_pc4[i]));
      check($sformatf("t4_ir%0d", i),  64'(xins[i]),    64'(exp_ins4[i]));
    end

    // 5: fetch_en low for 3 cycles while the buffer drains
    do_reset();
    fetch_en = 1'b1;
    ir_ready = 1'b0;
    repeat (8) cyc();
    clear_logs();
    fetch_en = 1'b0;
    ir_ready = 1'b1;
    repeat (3) cyc();
    check("t5_noreq",  64'(req_log.size()), 64'd0);
    check("t5_ndrain", 64'(xpc.size()),     64'd2);
    check("t5_pc0",    64'(xpc[0]),         64'h0);
    check("t5_pc1",    64'(xpc[1]),         64'h4);
    #1;
    check("t5_empty",  64'(ir_valid),       64'd0);
    fetch_en = 1'b1;
    wait_req("t5_resume", 10);
    check("t5_resume_addr", 64'(imem_addr), 64'h8);

    // 6: reset while a request is outstanding
    do_reset();
    fetch_en = 1'b1;
    ir_ready = 1'b0;
    cyc();
    cyc();
    #1;
    check("t6_req_before_rst", 64'(imem_req), 64'd1);
    sys_rst_n = 1'b0;
    cyc();
    sys_rst_n = 1'b1;
    fetch_en = 1'b0;
    #1;
    check("t6_req",   64'(imem_req),  64'd0);
    check("t6_addr",  64'(imem_addr), 64'h0);
    check("t6_valid", 64'(ir_valid),  64'd0);
    check("t6_ir",    64'(ir_out),    64'h0);
    check("t6_pc",    64'(ir_pc),     64'h0);
    cyc();
    #1;
    check("t6_late_ignored", 64'(ir_valid), 64'd0);
    fetch_en = 1'b1;
    ir_ready = 1'b1;
    clear_logs();
    wait_req("t6_restart", 10);
    check("t6_restart_addr", 64'(imem_addr), 64'h0);
    wait_xfer("t6_xfer", 1, 10);
    check("t6_pc0", 64'(xpc[0]),  64'h0);
    check("t6_ir0", 64'(xins[0]), 64'h200000C2);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

endmodule
